// File: rtl/mult_cell_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_cell_arbiter
// Purpose  : Shares one pipelined multiply cell between two requester lanes.
//            Each lane runs IDLE -> WAIT -> DONE and holds one operation at a
//            time. A {valid, lane} tag pipeline routes each product back to
//            the lane that issued it.
// Options  : MULT_ARB_FIXED_PRIO_EN - lane 0 always wins contention
//            (default build: round-robin on the last granted lane)
// Revision : 1.0 - initial release
// ============================================================================
module mult_cell_arbiter #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp0_result,
  output logic [31:0] rsp1_result,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [31:0] mul_result,
  output logic        arb_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lane_state_t;

  lane_state_t state_q [2];
  lane_state_t state_d [2];

  logic [1:0]  req_valid_v;
  logic [1:0]  rsp_ready_v;
  logic [1:0]  eligible;
  logic [1:0]  grant;
  logic [1:0]  capture;
  logic [31:0] result_q [2];

  // Tag pipeline: stage 0 is written in the grant cycle, the last stage is
  // the tag whose product is on mul_result in the current cycle.
  logic [MUL_LATENCY-1:0] pipe_valid;
  logic [MUL_LATENCY-1:0] pipe_lane;
  logic                   exit_valid;
  logic                   exit_lane;

  assign req_valid_v = {req1_valid, req0_valid};
  assign rsp_ready_v = {rsp1_ready, rsp0_ready};
  assign exit_valid  = pipe_valid[MUL_LATENCY-1];
  assign exit_lane   = pipe_lane[MUL_LATENCY-1];
  assign capture[0]  = exit_valid && !exit_lane;
  assign capture[1]  = exit_valid &&  exit_lane;

  // A lane may be granted only from IDLE (registered state), never in reset.
  always_comb begin
    eligible = 2'b00;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = !reset && (state_q[i] == IDLE) && req_valid_v[i];
    end
  end

`ifdef MULT_ARB_FIXED_PRIO_EN
  // Fixed priority: lane 0 wins whenever both lanes are eligible.
  always_comb begin
    grant    = 2'b00;
    grant[0] = eligible[0];
    grant[1] = eligible[1] && !eligible[0];
  end
`else
  // Last granted lane; reset value 1 so lane 0 wins the first contention.
  logic last_grant;

  // Round-robin: under contention the lane not granted most recently wins.
  always_comb begin
    grant = eligible;
    if (eligible == 2'b11) begin
      grant[0] = last_grant;
      grant[1] = !last_grant;
    end
  end

  // Pointer moves only when a grant actually happens.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant != 2'b00) begin
      last_grant <= grant[1];
    end
  end
`endif

  // Granted lane's operands go straight to the multiply cell; zero otherwise.
  always_comb begin
    mul_src1 = 32'h0;
    mul_src2 = 32'h0;
    if (grant[0]) begin
      mul_src1 = req0_src1;
      mul_src2 = req0_src2;
    end else if (grant[1]) begin
      mul_src1 = req1_src1;
      mul_src2 = req1_src2;
    end
  end

  // Shift the {valid, lane} tag alongside the multiply cell's latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_lane  <= '0;
    end else begin
      pipe_valid[0] <= |grant;
      pipe_lane[0]  <= grant[1];
      for (int k = 1; k < MUL_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_lane[k]  <= pipe_lane[k-1];
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q[0] <= IDLE;
      state_q[1] <= IDLE;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
    end
  end

  // Lane next-state: grant -> WAIT, tagged product -> DONE, consumed -> IDLE.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE:    if (grant[i])       state_d[i] = WAIT;
        WAIT:    if (capture[i])     state_d[i] = DONE;
        DONE:    if (rsp_ready_v[i]) state_d[i] = IDLE;
        default:                     state_d[i] = IDLE;
      endcase
    end
  end

  // Capture the product into the tagged lane only; held until next capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q[0] <= 32'h0;
      result_q[1] <= 32'h0;
    end else begin
      if (capture[0]) result_q[0] <= mul_result;
      if (capture[1]) result_q[1] <= mul_result;
    end
  end

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign rsp0_valid  = (state_q[0] == DONE);
  assign rsp1_valid  = (state_q[1] == DONE);
  assign rsp0_result = result_q[0];
  assign rsp1_result = result_q[1];
  assign arb_busy    = (state_q[0] != IDLE) || (state_q[1] != IDLE);

endmodule
`default_nettype wire

// File: doc/mult_cell_arbiter.md
MULT_CELL_ARBITER -- requirements
Module: mult_cell_arbiter

Interface
REQ-001 The block SHALL have parameter MUL_LATENCY, default 1 (legal 1..4), meaning cycles from operands on mul_src1/mul_src2 to the product on mul_result.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester i has an operation pending
- req0_ready / req1_ready  out  1  requester i operation accepted this cycle
- req0_src1, req0_src2, req1_src1, req1_src2  in  32  operands for requester i
- rsp0_valid / rsp1_valid  out  1  result for requester i is held
- rsp0_ready / rsp1_ready  in  1  requester i consumes its result
- rsp0_result / rsp1_result  out  32  low 32 bits of src1*src2 for requester i
- mul_src1, mul_src2  out  32  operands driven to the shared multiply cell
- mul_result  in  32  multiply cell product, MUL_LATENCY cycles after operands
- arb_busy  out  1  any lane not IDLE

Function
REQ-003 Each lane i SHALL have a 3-state FSM: IDLE -> WAIT on req_i handshake; WAIT -> DONE when its tag exits the latency pipeline; DONE -> IDLE on rsp_valid_i && rsp_ready_i.
REQ-004 A lane SHALL only be granted from IDLE; each lane has at most one operation outstanding.
REQ-005 At most one grant SHALL occur per cycle; req_ready_i is combinational, high only if lane i is IDLE, req_valid_i is high, and the arbiter selects i.
REQ-006 With exactly one eligible lane, that lane SHALL be granted; with both eligible, round-robin applies: the lane not granted most recently wins.
REQ-007 The last-grant pointer SHALL update only on a grant.
REQ-008 In the grant cycle, mul_src1/mul_src2 SHALL combinationally carry the granted lane's operands; with no grant, both SHALL be 32'h0.
REQ-009 The block SHALL carry a MUL_LATENCY-deep shift pipeline of {valid, lane id}; the entry for a grant in cycle T exits in cycle T+MUL_LATENCY.
REQ-010 In cycle T+MUL_LATENCY, mul_result SHALL be captured into rsp_result of the tagged lane, and rsp_valid of that lane SHALL be high from T+MUL_LATENCY+1.
REQ-011 rsp_result SHALL be unsigned modulo 2^32 (low word of product), held stable while in DONE.
REQ-012 A lane in DONE with rsp_ready low SHALL hold rsp_valid and rsp_result indefinitely; the other lane continues unaffected.
REQ-013 A lane returning to IDLE in cycle C SHALL be eligible for grant no earlier than cycle C+1 (rsp handshake and new grant never in the same cycle for one lane).
REQ-014 Two lanes MAY be in flight simultaneously (pipelined, consecutive grants); each capture SHALL go only to its tagged lane.
REQ-015 arb_busy SHALL be high whenever either lane is WAIT or DONE.

Reset
REQ-016 On a clock edge with reset high: both lanes IDLE, pipeline valids 0, last-grant pointer = lane 1 (so lane 0 wins the first contention), rsp_valid 0, rsp_result 32'h0, arb_busy 0.
REQ-017 While reset is high, req_ready SHALL be 0 and mul_src1/mul_src2 SHALL be 32'h0.
REQ-018 Reset mid-operation SHALL discard in-flight products; no rsp_valid SHALL follow from operations granted before reset.

Configuration
REQ-019 Macro MULT_ARB_FIXED_PRIO_EN, when defined, SHALL replace round-robin with fixed priority: lane 0 always wins contention, and the pointer is unused.
REQ-020 Without MULT_ARB_FIXED_PRIO_EN, REQ-006/REQ-007 round-robin SHALL apply; all other behaviour is identical in both builds.

Verification
REQ-021 MUL_LATENCY=1, reset, then req0 valid with src 3,5 -> req0_ready in that cycle, mul_src1=3, mul_src2=5, rsp0_valid 2 cycles later with rsp0_result=15.
REQ-022 Both valid from the same cycle, rsp_ready held 1 -> grant order lane0, lane1, lane0, lane1 (round-robin); with MULT_ARB_FIXED_PRIO_EN, lane0 is granted whenever IDLE.
REQ-023 src1=32'hFFFF_FFFF, src2=2 -> rsp_result=32'hFFFF_FFFE.
REQ-024 MUL_LATENCY=3, lane1 granted at T, lane0 at T+1 -> rsp1_valid at T+4, rsp0_valid at T+5, each result correct.
REQ-025 rsp0_ready held 0 for 10 cycles -> rsp0_valid/rsp0_result stable, req0_ready stays 0, lane1 operations still complete.
REQ-026 Reset asserted the cycle after a grant -> no rsp_valid ever, arb_busy 0 after the reset edge, next request gets correct result.
